icache_dataram_arb: RTL and testbench

Arbiter and sequencer for the shared icache data RAM port. It collects paired A/B dataram read requests from all MSHR entries and linefill write requests from the downstream response path, and selects one request per cycle. The selected request goes through a single registered output stage to the dataram. It sits between the MSHR entry array and the dataram controller, and is the only driver of the dataram request interface.

---
 rtl/toy_pack.sv | 35 +++
 rtl/icache_rr_arb.sv | 54 +++++
 rtl/icache_dataram_arb.sv | 120 ++++++++++++
 tb/tb_icache_dataram_arb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/toy_pack.sv
// Shared icache types and sizing constants for the MSHR array and the data RAM path.
// Holds dataram read/write payloads and the arbitrated dataram request format.
package toy_pack;

   localparam int MSHR_ENTRY_NUM  = 8;
   localparam int WR_STARVE_LIMIT = 4;

   localparam int WAY_W       = 2;
   localparam int IDX_W       = 6;
   localparam int TXNID_W     = 4;
   localparam int LINE_DATA_W = 32;
   localparam int ENTRY_ID_W  = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1;

   typedef struct packed {
      logic [WAY_W-1:0]   way;
      logic [IDX_W-1:0]   index;
      logic [TXNID_W-1:0] txnid;
   } dataram_rd_pld_t;

   typedef struct packed {
      logic [WAY_W-1:0]       way;
      logic [IDX_W-1:0]       index;
      logic [LINE_DATA_W-1:0] data;
      logic                   line_a;
   } dataram_wr_pld_t;

   typedef struct packed {
      logic                  is_wr;
      logic [ENTRY_ID_W-1:0] entry_id;
      dataram_rd_pld_t       rdA;
      dataram_rd_pld_t       rdB;
      dataram_wr_pld_t       wr;
   } dataram_req_t;

endpackage

// File: rtl/icache_rr_arb.sv
// N-way round-robin picker: searches from the pointer upward, reports a one-hot grant,
// and moves the pointer just past the winner when adv is asserted.
module icache_rr_arb #(
   parameter int N = 8,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          adv,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] ptr_next;

   // Walk offsets from farthest to nearest so the entry closest to the pointer wins.
   always_comb begin
      int k;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      k       = 0;
      for (int o = N - 1; o >= 0; o--) begin
         k = int'(ptr_reg) + o;
         if (k >= N) k = k - N;
         if (req[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = IW'(k);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_gnt
      assign gnt[gi] = gnt_vld && (gnt_idx == IW'(gi));
   end

   always_comb begin
      ptr_next = ptr_reg;
      if (adv && gnt_vld) begin
         ptr_next = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/icache_dataram_arb.sv
// Arbiter for the shared icache data RAM port: linefill writes beat MSHR A/B reads,
// reads are round-robin, one registered request stage. Optional: ICACHE_DATARAM_ARB_STARVE_EN.
module icache_dataram_arb #(
   parameter int MSHR_ENTRY_NUM  = toy_pack::MSHR_ENTRY_NUM,
   parameter int WR_STARVE_LIMIT = toy_pack::WR_STARVE_LIMIT
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [MSHR_ENTRY_NUM-1:0]                    v_rd_vld,
   input  toy_pack::dataram_rd_pld_t [MSHR_ENTRY_NUM-1:0] v_rd_pldA,
   input  toy_pack::dataram_rd_pld_t [MSHR_ENTRY_NUM-1:0] v_rd_pldB,
   output logic [MSHR_ENTRY_NUM-1:0]                    v_rd_rdy,
   input  logic                                         linefill_wr_vld,
   input  toy_pack::dataram_wr_pld_t                    linefill_wr_pld,
   output logic                                         linefill_wr_rdy,
   output logic                                         dataram_req_vld,
   output toy_pack::dataram_req_t                       dataram_req_pld,
   input  logic                                         dataram_req_rdy
);

   localparam int IW = (MSHR_ENTRY_NUM > 1) ? $clog2(MSHR_ENTRY_NUM) : 1;

   if (WR_STARVE_LIMIT < 1) begin : g_bad_limit
      $error("WR_STARVE_LIMIT must be at least 1");
   end

   logic                      stage_free;
   logic                      force_rd;
   logic                      wr_gnt;
   logic                      rd_gnt;
   logic [MSHR_ENTRY_NUM-1:0] rr_gnt;
   logic [IW-1:0]             rr_idx;
   logic                      rr_vld;

   logic                      req_vld_reg;
   toy_pack::dataram_req_t    req_reg;
   toy_pack::dataram_req_t    req_next;

   // A draining stage can be refilled in the same cycle, so back-to-back requests see no bubble.
   assign stage_free = !req_vld_reg || dataram_req_rdy;
   assign wr_gnt     = !rst && stage_free && linefill_wr_vld && !force_rd;
   assign rd_gnt     = !rst && stage_free && rr_vld && !wr_gnt;

   icache_rr_arb #(
      .N (MSHR_ENTRY_NUM)
   ) u_rd_rr (
      .clk     (clk),
      .rst     (rst),
      .req     (v_rd_vld),
      .adv     (rd_gnt),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx),
      .gnt_vld (rr_vld)
   );

   for (genvar gi = 0; gi < MSHR_ENTRY_NUM; gi++) begin : g_rd_rdy
      assign v_rd_rdy[gi] = rd_gnt && rr_gnt[gi];
   end

   assign linefill_wr_rdy = wr_gnt;

`ifdef ICACHE_DATARAM_ARB_STARVE_EN
   localparam int SW = $clog2(WR_STARVE_LIMIT + 1);

   logic [SW-1:0] starve_cnt_reg;
   logic [SW-1:0] starve_cnt_next;
   logic          rd_pending;

   assign rd_pending = |v_rd_vld;
   assign force_rd   = rd_pending && (starve_cnt_reg == SW'(WR_STARVE_LIMIT));

   // Counts writes that overtook a waiting read; stalled cycles leave it unchanged.
   always_comb begin
      starve_cnt_next = starve_cnt_reg;
      if (rd_gnt || !rd_pending) begin
         starve_cnt_next = '0;
      end else if (wr_gnt && (starve_cnt_reg != SW'(WR_STARVE_LIMIT))) begin
         starve_cnt_next = starve_cnt_reg + SW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt_reg <= '0;
      end else begin
         starve_cnt_reg <= starve_cnt_next;
      end
   end
`else
   assign force_rd = 1'b0;
`endif

   always_comb begin
      req_next       = '0;
      req_next.is_wr = wr_gnt;
      if (wr_gnt) begin
         req_next.wr = linefill_wr_pld;
      end else begin
         req_next.entry_id = toy_pack::ENTRY_ID_W'(rr_idx);
         req_next.rdA      = v_rd_pldA[rr_idx];
         req_next.rdB      = v_rd_pldB[rr_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_vld_reg <= 1'b0;
         req_reg     <= '0;
      end else if (wr_gnt || rd_gnt) begin
         req_vld_reg <= 1'b1;
         req_reg     <= req_next;
      end else if (dataram_req_rdy) begin
         req_vld_reg <= 1'b0;
      end
   end

   assign dataram_req_vld = req_vld_reg;
   assign dataram_req_pld = req_reg;

endmodule

// File: tb/tb_icache_dataram_arb.sv
// Randomized scoreboard bench for icache_dataram_arb: a rule-level model predicts grants
// each cycle and queues the expected dataram request; a monitor compares the output stage.
module tb_icache_dataram_arb;
   import toy_pack::*;

   localparam int N     = MSHR_ENTRY_NUM;
   localparam int LIMIT = WR_STARVE_LIMIT;

   logic                             clk;
   logic                             rst;
   logic [N-1:0]                     v_rd_vld;
   dataram_rd_pld_t [N-1:0]          v_rd_pldA;
   dataram_rd_pld_t [N-1:0]          v_rd_pldB;
   logic [N-1:0]                     v_rd_rdy;
   logic                             linefill_wr_vld;
   dataram_wr_pld_t                  linefill_wr_pld;
   logic                             linefill_wr_rdy;
   logic                             dataram_req_vld;
   dataram_req_t                     dataram_req_pld;
   logic                             dataram_req_rdy;

   icache_dataram_arb dut (
      .clk             (clk),
      .rst             (rst),
      .v_rd_vld        (v_rd_vld),
      .v_rd_pldA       (v_rd_pldA),
      .v_rd_pldB       (v_rd_pldB),
      .v_rd_rdy        (v_rd_rdy),
      .linefill_wr_vld (linefill_wr_vld),
      .linefill_wr_pld (linefill_wr_pld),
      .linefill_wr_rdy (linefill_wr_rdy),
      .dataram_req_vld (dataram_req_vld),
      .dataram_req_pld (dataram_req_pld),
      .dataram_req_rdy (dataram_req_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   dataram_req_t exp_q[$];

   // Reference model state, kept as plain integers and flags.
   int     m_rr     = 0;
   bit     m_occ    = 0;
   int     m_starve = 0;
   bit [N-1:0] last_rd_gnt = '0;
   bit     last_wr_gnt = 0;

   int rd_pct  = 0;
   int wr_pct  = 0;
   int rdy_pct = 100;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
      end
   endtask

   // One bench cycle: drive at posedge+1, predict and check grants at posedge+3.
   task automatic cycle_step(input bit rst_val);
      logic [31:0]    r32;
      logic [63:0]    r64;
      bit             free;
      bit             pending;
      bit             force_rd;
      bit             exp_wr;
      int             exp_k;
      bit [N-1:0]     exp_rd_vec;
      dataram_req_t   e;

      @(posedge clk);
      #1;
      rst = rst_val;
      for (int k = 0; k < N; k++) begin
         if (last_rd_gnt[k]) v_rd_vld[k] = 1'b0;
         if (!v_rd_vld[k] && ($urandom_range(0, 99) < rd_pct)) begin
            v_rd_vld[k] = 1'b1;
            r32 = $urandom;
            v_rd_pldA[k] = r32[$bits(dataram_rd_pld_t)-1:0];
            r32 = $urandom;
            v_rd_pldB[k] = r32[$bits(dataram_rd_pld_t)-1:0];
         end
      end
      if (last_wr_gnt) linefill_wr_vld = 1'b0;
      if (!linefill_wr_vld && ($urandom_range(0, 99) < wr_pct)) begin
         linefill_wr_vld = 1'b1;
         r64 = {$urandom, $urandom};
         linefill_wr_pld = r64[$bits(dataram_wr_pld_t)-1:0];
      end
      dataram_req_rdy = ($urandom_range(0, 99) < rdy_pct);

      #2;
      exp_wr     = 0;
      exp_k      = -1;
      exp_rd_vec = '0;
      pending    = (v_rd_vld != '0);
      if (rst_val) begin
         m_rr = 0; m_occ = 0; m_starve = 0;
      end else begin
         free = !m_occ || dataram_req_rdy;
`ifdef ICACHE_DATARAM_ARB_STARVE_EN
         force_rd = pending && (m_starve == LIMIT);
`else
         force_rd = 0;
`endif
         if (free && linefill_wr_vld && !force_rd) begin
            exp_wr = 1;
         end else if (free && pending) begin
            for (int o = N - 1; o >= 0; o--) begin
               if (v_rd_vld[(m_rr + o) % N]) exp_k = (m_rr + o) % N;
            end
            exp_rd_vec[exp_k] = 1'b1;
         end
`ifdef ICACHE_DATARAM_ARB_STARVE_EN
         if (exp_k >= 0 || !pending) m_starve = 0;
         else if (exp_wr && m_starve < LIMIT) m_starve++;
`endif
         if (exp_wr || exp_k >= 0) begin
            e = '0;
            if (exp_wr) begin
               e.is_wr = 1'b1;
               e.wr    = linefill_wr_pld;
            end else begin
               e.entry_id = exp_k[ENTRY_ID_W-1:0];
               e.rdA      = v_rd_pldA[exp_k];
               e.rdB      = v_rd_pldB[exp_k];
               m_rr       = (exp_k + 1) % N;
            end
            exp_q.push_back(e);
            m_occ = 1;
         end else if (free) begin
            m_occ = 0;
         end
      end
      chk("rd_grant", 128'(v_rd_rdy), 128'(exp_rd_vec));
      chk("wr_grant", 128'(linefill_wr_rdy), 128'(exp_wr));
      last_rd_gnt = exp_rd_vec;
      last_wr_gnt = exp_wr;
   endtask

   // Monitor: at posedge+2 the output stage must match the queue head; pop on transfer.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rst === 1'b1) begin
            exp_q.delete();
         end else begin
            chk("req_vld", 128'(dataram_req_vld), 128'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
               chk("req_pld", 128'(dataram_req_pld), 128'(exp_q[0]));
               if (dataram_req_rdy) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic run(input int cycles, input int rp, input int wp, input int dp);
      rd_pct = rp; wr_pct = wp; rdy_pct = dp;
      for (int i = 0; i < cycles; i++) cycle_step(1'b0);
   endtask

   initial begin
      rst             = 1'b1;
      v_rd_vld        = '0;
      v_rd_pldA       = '0;
      v_rd_pldB       = '0;
      linefill_wr_vld = 1'b0;
      linefill_wr_pld = '0;
      dataram_req_rdy = 1'b1;

      for (int i = 0; i < 3; i++) cycle_step(1'b1);
      run(1, 0, 0, 100);
      chk("reset_vld", 128'(dataram_req_vld), 128'(0));
      chk("reset_pld", 128'(dataram_req_pld), 128'(0));
      chk("reset_rdy", 128'({v_rd_rdy, linefill_wr_rdy}), 128'(0));

      run(20, 100, 0, 100);    // every entry busy: strict 0..7 rotation
      run(4, 100, 0, 0);       // dataram back-pressure: stage must hold
      run(20, 100, 0, 100);
      run(300, 30, 30, 60);    // mixed traffic
      run(60, 20, 100, 100);   // sustained linefill writes against sparse reads
      run(10, 100, 20, 50);
      cycle_step(1'b1);        // reset while requests are in flight
      run(20, 100, 20, 100);
      run(300, 50, 40, 70);
      run(10, 0, 0, 100);      // drain

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
